// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register. It issues req/ack fetches at pc,
// parks a returned word in a skid buffer while stalled, and flushes on redirect.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] IF_ID_instr,
  output logic [31:0] IF_ID_pc4,
  output logic        IF_ID_valid,
  output logic [5:0]  op
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, CANCEL} fetchState_t;

  fetchState_t state;
  logic        reqReg;
  logic [31:0] pcReg;
  logic [31:0] instrReg;
  logic [31:0] pc4Reg;
  logic        validReg;
  logic [31:0] skidInstr;
  logic [31:0] skidPc4;

  logic [31:0] pcPlus4;
  logic [31:0] redirectTarget;

  assign pcPlus4        = pcReg + 32'd4;
  assign redirectTarget = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      reqReg    <= 1'b0;
      pcReg     <= RESET_PC;
      instrReg  <= 32'd0;
      pc4Reg    <= 32'd0;
      validReg  <= 1'b0;
      skidInstr <= 32'd0;
      skidPc4   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state  <= FETCH;
          reqReg <= 1'b1;
        end

        FETCH: begin
          if (redirect) begin
            pcReg     <= redirectTarget;
            validReg  <= 1'b0;
            skidInstr <= 32'd0;
            skidPc4   <= 32'd0;
            // Without an ack the old request is still outstanding and must be abandoned
            if (imem_ack) begin
              state  <= FETCH;
              reqReg <= 1'b1;
            end else begin
              state  <= CANCEL;
              reqReg <= 1'b0;
            end
          end else if (imem_ack) begin
            pcReg <= pcPlus4;
            if (stall) begin
              skidInstr <= imem_rdata;
              skidPc4   <= pcPlus4;
              state     <= HOLD;
              reqReg    <= 1'b0;
            end else begin
              instrReg <= imem_rdata;
              pc4Reg   <= pcPlus4;
              validReg <= 1'b1;
            end
          end else if (!stall) begin
            validReg <= 1'b0;
          end
        end

        HOLD: begin
          if (redirect) begin
            pcReg     <= redirectTarget;
            validReg  <= 1'b0;
            skidInstr <= 32'd0;
            skidPc4   <= 32'd0;
            state     <= FETCH;
            reqReg    <= 1'b1;
          end else if (!stall) begin
            instrReg <= skidInstr;
            pc4Reg   <= skidPc4;
            validReg <= 1'b1;
            state    <= FETCH;
            reqReg   <= 1'b1;
          end
        end

        CANCEL: begin
          if (redirect) begin
            pcReg    <= redirectTarget;
            validReg <= 1'b0;
          end else begin
            state  <= FETCH;
            reqReg <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          reqReg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = reqReg;
  assign imem_addr   = pcReg;
  assign pc          = pcReg;
  assign IF_ID_instr = instrReg;
  assign IF_ID_pc4   = pc4Reg;
  assign IF_ID_valid = validReg;
  assign op          = validReg ? instrReg[31:26] : 6'b000000;

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Scoreboard bench for if_id_fetch_stage: directed per-cycle vectors push expected IF/ID
// words into a queue, and a monitor pops one each time a new instruction is latched.
module tb_if_id_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] IF_ID_instr;
  logic [31:0] IF_ID_pc4;
  logic        IF_ID_valid;
  logic [5:0]  op;

  logic ackV;
  logic staleV;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t expQ[$];
  int   checks;
  int   failures;

  if_id_fetch_stage #(.RESET_PC(32'h00000000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc         (pc),
    .IF_ID_instr(IF_ID_instr),
    .IF_ID_pc4  (IF_ID_pc4),
    .IF_ID_valid(IF_ID_valid),
    .op         (op)
  );

  // Memory returns a word derived from its address; staleV forces ack with no request
  assign imem_ack   = (imem_req & ackV) | staleV;
  assign imem_rdata = imem_addr ^ 32'hA5A50000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc4);
    exp_t e;
    e.instr = instr;
    e.pc4   = pc4;
    expQ.push_back(e);
  endtask

  // Drive inputs for the next rising edge, then return 2 time units after it
  task automatic cyc(input logic a, input logic s, input logic r, input logic [31:0] rp);
    ackV        = a;
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    @(posedge clk);
    #2;
  endtask

  // Monitor: a new IF/ID word was latched when valid is high after an unstalled edge
  initial begin
    logic stallAt;
    exp_t e;
    forever begin
      @(posedge clk);
      stallAt = stall;
      @(negedge clk);
      if (rst_n) begin
        if (IF_ID_valid && !stallAt) begin
          checks++;
          if (expQ.size() == 0) begin
            failures++;
            $display("FAIL unexpected_instr actual=%h/%h required=none", IF_ID_instr, IF_ID_pc4);
          end else begin
            e = expQ.pop_front();
            if (IF_ID_instr !== e.instr || IF_ID_pc4 !== e.pc4 || op !== e.instr[31:26]) begin
              failures++;
              $display("FAIL ifid_word actual=%h/%h/op%h required=%h/%h/op%h",
                       IF_ID_instr, IF_ID_pc4, op, e.instr, e.pc4, e.instr[31:26]);
            end else begin
              $display("tb: IF/ID instr=%h pc4=%h op=%h", IF_ID_instr, IF_ID_pc4, op);
            end
          end
        end else if (!IF_ID_valid) begin
          checks++;
          if (op !== 6'd0) begin
            failures++;
            $display("FAIL op_bubble actual=%h required=00", op);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    ackV        = 1'b0;
    staleV      = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("rst_instr", IF_ID_instr, 32'd0);
    chk("rst_pc4", IF_ID_pc4, 32'd0);
    chk("rst_op", {26'd0, op}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);

    // Back-to-back acks: one instruction per cycle
    push(32'hA5A50000, 32'd4);
    push(32'hA5A50004, 32'd8);
    push(32'hA5A50008, 32'd12);
    cyc(1, 0, 0, 0);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("b2b_pc", pc, 32'd12);

    // Latency-2 memory: bubbles between instructions
    push(32'hA5A5000C, 32'd16);
    push(32'hA5A50010, 32'd20);
    cyc(0, 0, 0, 0);
    chk("bubble_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("bubble_addr", imem_addr, 32'd12);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);

    // Stall for 3 cycles while an ack arrives
    push(32'hA5A50014, 32'd24);
    push(32'hA5A50018, 32'd28);
    cyc(1, 1, 0, 0);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_pc", pc, 32'd24);
    chk("hold_instr", IF_ID_instr, 32'hA5A50010);
    cyc(1, 1, 0, 0);
    chk("hold_instr2", IF_ID_instr, 32'hA5A50010);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("unhold_req", {31'd0, imem_req}, 32'd1);
    chk("unhold_addr", imem_addr, 32'd24);
    cyc(1, 0, 0, 0);

    // Redirect with request in flight, stale ack during CANCEL, redirect+ack dropped
    push(32'hA5A50208, 32'h20C);
    cyc(0, 0, 1, 32'h00000103);
    chk("cancel_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("cancel_req", {31'd0, imem_req}, 32'd0);
    chk("cancel_pc", pc, 32'h100);
    staleV = 1'b1;
    cyc(1, 0, 0, 0);
    staleV = 1'b0;
    chk("refetch_req", {31'd0, imem_req}, 32'd1);
    chk("refetch_addr", imem_addr, 32'h100);
    chk("stale_valid", {31'd0, IF_ID_valid}, 32'd0);
    cyc(1, 0, 1, 32'h0000020A);
    chk("redir_ack_pc", pc, 32'h208);
    chk("redir_ack_valid", {31'd0, IF_ID_valid}, 32'd0);
    cyc(1, 0, 0, 0);

    // Redirect and stall together in HOLD: skid word is discarded
    push(32'hA5A50300, 32'h304);
    cyc(1, 1, 0, 0);
    chk("hold2_pc", pc, 32'h210);
    cyc(0, 1, 1, 32'h00000300);
    chk("hold_redir_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("hold_redir_addr", imem_addr, 32'h300);
    chk("hold_redir_req", {31'd0, imem_req}, 32'd1);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);

    // PC wrap at the top of the address space
    push(32'h5A5AFFFC, 32'h0);
    push(32'hA5A50000, 32'd4);
    cyc(1, 0, 1, 32'hFFFFFFFF);
    chk("wrap_pc", pc, 32'hFFFFFFFC);
    cyc(1, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    cyc(1, 0, 0, 0);

    // Asynchronous reset in the middle of a request
    @(negedge clk);
    #1;
    ackV  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_valid", {31'd0, IF_ID_valid}, 32'd0);
    chk("async_pc", pc, 32'h0);
    chk("async_op", {26'd0, op}, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    chk("rerun_req", {31'd0, imem_req}, 32'd1);
    chk("rerun_addr", imem_addr, 32'h0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("queue_empty", expQ.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the opcode decoder.
- Holds the PC and issues requests to instruction memory over a req/ack handshake.
- Buffers the returned word through stalls, and flushes/redirects on taken branches and jumps.
- Presents the latched instruction, its PC+4 and a valid flag; op feeds the decoder.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset (bits [1:0] must be 0).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request, held until ack.
- imem_addr  output  32  word-aligned fetch address (= pc).
- imem_ack  input  1  memory returns imem_rdata this cycle; ignored unless imem_req=1.
- imem_rdata  input  32  instruction word, valid with imem_ack.
- stall  input  1  hazard unit: hold IF/ID contents.
- redirect  input  1  taken branch/jump: flush and reload PC.
- redirect_pc  input  32  new PC; bits [1:0] ignored (forced 0).
- pc  output  32  current fetch PC.
- IF_ID_instr  output  32  latched instruction.
- IF_ID_pc4  output  32  PC+4 of latched instruction.
- IF_ID_valid  output  1  IF/ID holds a real instruction.
- op  output  6  IF_ID_instr[31:26]; 6'b000000 when IF_ID_valid=0.

Behaviour:
- Reset (rst_n low, any time, asynchronous):
  - pc=RESET_PC; IF_ID_instr=0; IF_ID_pc4=0; IF_ID_valid=0.
  - Skid buffer cleared; state=IDLE; imem_req=0.
- States: IDLE, FETCH, HOLD, CANCEL.
  - imem_req=1 only in FETCH.
  - imem_addr=pc at all times.
- IDLE: unconditionally go to FETCH on the next edge (first request one cycle after reset release).
- FETCH, no ack:
  - stall=0: IF_ID_valid<=0 (bubble).
  - stall=1: IF/ID unchanged.
  - Stay in FETCH; pc and imem_addr stable.
- FETCH, ack and stall=0:
  - IF_ID_instr<=imem_rdata, IF_ID_pc4<=pc+4, IF_ID_valid<=1.
  - pc<=pc+4; stay in FETCH. Back-to-back acks give one instruction per cycle.
- FETCH, ack and stall=1:
  - imem_rdata and pc+4 go into the skid buffer; pc<=pc+4; go to HOLD.
  - IF/ID unchanged.
- HOLD: imem_req=0.
  - stall=0: IF/ID<=skid buffer, IF_ID_valid<=1, go to FETCH.
  - stall=1: remain in HOLD.
- Redirect has highest priority, over stall and ack, in any state except IDLE:
  - pc<={redirect_pc[31:2],2'b00}; IF_ID_valid<=0; skid buffer discarded.
  - An ack arriving in the same cycle is dropped.
  - From FETCH without ack (request in flight): go to CANCEL. CANCEL holds imem_req=0 for one cycle to abandon the request, then goes to FETCH.
  - Otherwise go directly to FETCH.
  - A redirect during CANCEL updates pc again and stays in CANCEL one more cycle.
- Arithmetic: 32-bit, modulo. pc 32'hFFFFFFFC +4 wraps to 32'h00000000 with no flag.
- Latency: ack at edge N gives IF_ID_valid=1 after edge N, when not stalled.
- While IF_ID_valid=0, IF_ID_instr is don't-care, but op must read 0.
- Redirect and stall asserted together: redirect wins and IF/ID is flushed, not held.

Test Plan:
- Reset release, RESET_PC=0, memory acks every cycle with rdata=pc^32'hA5A50000:
  - imem_req rises 1 cycle after release.
  - IF/ID shows the instr at pc 0, 4, 8 on consecutive cycles, with IF_ID_pc4=4, 8, 12.
- Ack-latency 2 memory: each instruction appears once. IF_ID_valid toggles 0/1 with bubbles; op=0 during bubbles.
- stall=1 for 3 cycles while an ack arrives:
  - IF/ID holds its old value; state goes to HOLD; imem_req=0.
  - On stall release the buffered word appears; no instruction is lost or duplicated; the next request is to the buffered pc+4.
- redirect=1, redirect_pc=32'h00000103, with a request in flight:
  - IF_ID_valid=0 next cycle; imem_req low for 1 cycle.
  - Next fetch at 32'h00000100; the stale ack is ignored.
- redirect and stall together in HOLD: the buffer is discarded, IF_ID_valid=0, and fetch resumes at the new PC.
- pc=32'hFFFFFFFC acked: IF_ID_pc4=0 and the next imem_addr is 0. Asserting rst_n=0 mid-request immediately drops imem_req and valid, and sets pc=RESET_PC.
